// File: rtl/serial_ram_pkg.sv
// Shared opcodes, state encoding and frame sizing for the serial RAM controller.
package serial_ram_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } state_e;

    function automatic int unsigned frame_bits(int unsigned addr_w, int unsigned data_w);
        return 8 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/serial_ram_tick.sv
// Half-period timebase: one-cycle tick every HALF_DIV clocks, realigned by restart_i.
module serial_ram_tick #(
    parameter int unsigned HALF_DIV = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o,
    output logic tick_next_o
);

    localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart_i || (cnt_q == '0)) begin
            cnt_d = LOAD;
        end
    end

    assign tick_o = (cnt_q == '0);
    // Lets the FSM register an output that must be valid in the tick cycle itself.
    assign tick_next_o = (cnt_d == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_ram_ctrl.sv
// Framed SPI mode 0 master for the bit-serial RAM: one opcode/address/data word per request.
module serial_ram_ctrl
    import serial_ram_pkg::*;
#(
    parameter int unsigned HALF_DIV = 11,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              cs_n_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    localparam int unsigned FRAME_W = frame_bits(ADDR_W, DATA_W);
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);

    state_e             state_q;
    logic [FRAME_W-1:0] tx_q;
    logic [DATA_W-1:0]  rx_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic               we_q;
    logic               ready_q;
    logic               done_q;
    logic               cs_n_q;
    logic               sclk_q;
    logic               mosi_q;

    logic               tick;
    logic               tick_next;
    logic               restart;
    logic               accept;
    logic               last_fall;
    logic [FRAME_W-1:0] frame;

    assign frame = {(we_i ? OP_WRITE : OP_READ), addr_i, (we_i ? wdata_i : {DATA_W{1'b0}})};

    // ready_q is only high in IDLE and in the final CS_GAP cycle, so a waiting request
    // restarts the frame with exactly HALF_DIV cycles of cs high.
    assign accept    = ready_q & req_i;
    assign last_fall = (state_q == SHIFT) && tick && sclk_q && (bit_cnt_q == BIT_W'(1));
    assign restart   = accept | last_fall |
                       (tick & (state_q inside {CS_SETUP, CS_HOLD, CS_GAP}));

    serial_ram_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .restart_i   (restart),
        .tick_o      (tick),
        .tick_next_o (tick_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            bit_cnt_q <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q   <= CS_SETUP;
                ready_q   <= 1'b0;
                cs_n_q    <= 1'b0;
                sclk_q    <= 1'b0;
                we_q      <= we_i;
                tx_q      <= frame;
                mosi_q    <= frame[FRAME_W-1];
                bit_cnt_q <= BIT_W'(FRAME_W);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        ready_q <= 1'b1;
                    end
                    CS_SETUP: begin
                        if (tick) begin
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            sclk_q <= ~sclk_q;
                            if (!sclk_q) begin
                                rx_q <= {rx_q[DATA_W-2:0], miso_i};
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 1'b1;
                                if (last_fall) begin
                                    state_q <= CS_HOLD;
                                end else begin
                                    mosi_q <= tx_q[FRAME_W-2];
                                    tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
                                end
                            end
                        end
                    end
                    CS_HOLD: begin
                        if (tick) begin
                            state_q <= CS_GAP;
                            cs_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                            ready_q <= tick_next;
                            if (!we_q) begin
                                rdata_q <= rx_q;
                            end
                        end
                    end
                    CS_GAP: begin
                        if (tick) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            ready_q <= tick_next;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign cs_n_o  = cs_n_q;
    assign sclk_o  = sclk_q;
    assign mosi_o  = mosi_q;

endmodule

// File: tb/tb_serial_ram_ctrl.sv
// Scoreboard bench: two controllers (HALF_DIV 11 and 1) each driving a behavioural serial RAM.
module tb_serial_ram_ctrl;
    import serial_ram_pkg::*;

    localparam int unsigned N = 32;

    typedef struct {
        int          dut;
        logic [31:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req[2];
    logic       we[2];
    logic [15:0] addr[2];
    logic [7:0] wdata[2];
    logic       ready[2];
    logic       done[2];
    logic [7:0] rdata[2];
    logic       cs_n[2];
    logic       sclk[2];
    logic       mosi[2];
    logic       miso[2] = '{1'b0, 1'b0};

    serial_ram_ctrl #(.HALF_DIV(11), .ADDR_W(16), .DATA_W(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .ready_o(ready[0]), .done_o(done[0]), .rdata_o(rdata[0]),
        .cs_n_o(cs_n[0]), .sclk_o(sclk[0]), .mosi_o(mosi[0]), .miso_i(miso[0])
    );

    serial_ram_ctrl #(.HALF_DIV(1), .ADDR_W(16), .DATA_W(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .ready_o(ready[1]), .done_o(done[1]), .rdata_o(rdata[1]),
        .cs_n_o(cs_n[1]), .sclk_o(sclk[1]), .mosi_o(mosi[1]), .miso_i(miso[1])
    );

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [7:0] last_rd[2] = '{8'h00, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ram_word(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h2C;
    endfunction

    function automatic int hd(input int d);
        return (d == 0) ? 11 : 1;
    endfunction

    function automatic void push_exp(input int d, input logic w, input logic [15:0] a,
                                     input logic [7:0] wd);
        exp_t e;
        e.dut   = d;
        e.frame = {(w ? OP_WRITE : OP_READ), a, (w ? wd : 8'h00)};
        if (!w) last_rd[d] = ram_word(a);
        e.rdata = last_rd[d];
        sb.push_back(e);
    endfunction

    // RAM model and frame monitor, sampled mid-cycle.
    int          rises[2];
    int          low_cnt[2];
    int          hi_cnt[2];
    int          last_gap[2];
    int          per_min[2];
    int          per_max[2];
    int          last_rise[2];
    int          since[2] = '{-1, -1};
    logic [31:0] cap[2];
    logic        is_rd[2];
    logic [7:0]  word[2];
    logic        prev_cs[2] = '{1'b1, 1'b1};
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    logic        prev_done[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] w;
        int         p;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (cs_n[d]) begin
                if (!prev_cs[d]) hi_cnt[d] = 0;
                hi_cnt[d]++;
            end else begin
                if (prev_cs[d]) begin
                    last_gap[d] = hi_cnt[d];
                    rises[d]    = 0;
                    cap[d]      = '0;
                    low_cnt[d]  = 0;
                    is_rd[d]    = 1'b0;
                    per_min[d]  = 100000;
                    per_max[d]  = 0;
                end
                low_cnt[d]++;
            end
            if (!cs_n[d] && sclk[d] && !prev_sclk[d]) begin
                cap[d] = {cap[d][30:0], mosi[d]};
                rises[d]++;
                if (rises[d] >= 2) begin
                    p = cyc - last_rise[d];
                    if (p < per_min[d]) per_min[d] = p;
                    if (p > per_max[d]) per_max[d] = p;
                end
                last_rise[d] = cyc;
                if (rises[d] == 24) begin
                    is_rd[d] = (cap[d][23:16] == OP_READ);
                    word[d]  = ram_word(cap[d][15:0]);
                end
            end
            if (!cs_n[d] && !sclk[d] && prev_sclk[d]) begin
                w = word[d];
                if (is_rd[d] && rises[d] >= 24 && rises[d] < 32) miso[d] = w[31 - rises[d]];
                else miso[d] = 1'($urandom);
            end
            if (done[d]) begin
                check($sformatf("dut%0d done_single_pulse", d), 32'(prev_done[d]), 0);
                if (sb.size() == 0 || sb[0].dut != d) begin
                    check($sformatf("dut%0d unexpected_done", d), 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("dut%0d mosi_frame", d), cap[d], e.frame);
                    check($sformatf("dut%0d sclk_rises", d), rises[d], N);
                    check($sformatf("dut%0d cs_low_cycles", d), low_cnt[d], (2 * N + 2) * hd(d));
                    check($sformatf("dut%0d sclk_period_min", d), per_min[d], 2 * hd(d));
                    check($sformatf("dut%0d sclk_period_max", d), per_max[d], 2 * hd(d));
                    check($sformatf("dut%0d rdata", d), rdata[d], e.rdata);
                    since[d] = 0;
                end
            end
            if (since[d] >= 0) begin
                if (ready[d]) begin
                    check($sformatf("dut%0d ready_after_done", d), since[d], hd(d) - 1);
                    since[d] = -1;
                end else begin
                    since[d]++;
                end
            end
            prev_cs[d]   = cs_n[d];
            prev_sclk[d] = sclk[d];
            prev_done[d] = done[d];
        end
    end

    task automatic send(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd,
                        input logic track);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready[d] && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("dut%0d ready_before_req", d), 32'(ready[d]), 1);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        if (track) push_exp(d, w, a, wd);
        @(posedge clk);
        #1;
        req[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !ready[d]) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("dut%0d idle_reached", d), 32'(sb.size() == 0 && ready[d] === 1'b1), 1);
    endtask

    initial begin
        int t;
        int extra;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d rst_ready", d), 32'(ready[d]), 1);
            check($sformatf("dut%0d rst_done", d), 32'(done[d]), 0);
            check($sformatf("dut%0d rst_rdata", d), 32'(rdata[d]), 0);
            check($sformatf("dut%0d rst_cs_n", d), 32'(cs_n[d]), 1);
            check($sformatf("dut%0d rst_sclk", d), 32'(sclk[d]), 0);
            check($sformatf("dut%0d rst_mosi", d), 32'(mosi[d]), 0);
        end
        rst = 1'b0;

        send(0, 1'b1, 16'h1234, 8'hA5, 1'b1);
        wait_idle(0);
        send(0, 1'b0, 16'h0010, 8'h00, 1'b1);
        wait_idle(0);
        check("dut0 read_0010", 32'(rdata[0]), 32'h3C);

        // Back-to-back: req held high across two accepts.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0F0F; wdata[0] = 8'h00;
        push_exp(0, 1'b0, 16'h0F0F, 8'h00);
        @(posedge clk);
        #1;
        we[0] = 1'b1; addr[0] = 16'hBEEF; wdata[0] = 8'h5A;
        push_exp(0, 1'b1, 16'hBEEF, 8'h5A);
        t = 0;
        @(negedge clk);
        while (!ready[0] && t < 5000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("dut0 b2b_accept_ready", 32'(ready[0]), 0);
        check("dut0 b2b_accept_cs_n", 32'(cs_n[0]), 0);
        req[0] = 1'b0;
        wait_idle(0);
        check("dut0 b2b_cs_high_cycles", last_gap[0], 11);

        // Requests while busy must be dropped, not queued or latched.
        send(0, 1'b0, 16'h4321, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req[0] = i[0]; we[0] = 1'b1; addr[0] = 16'hFFFF ^ 16'(i); wdata[0] = 8'(i);
        end
        @(negedge clk);
        req[0] = 1'b0;
        wait_idle(0);
        extra = 0;
        repeat (800) begin
            @(negedge clk);
            if (!cs_n[0]) extra++;
        end
        check("dut0 no_queued_frame", extra, 0);

        // Abort a read during the 10th sclk high phase.
        send(0, 1'b0, 16'h0055, 8'h00, 1'b0);
        t = 0;
        while (!(rises[0] == 10 && sclk[0]) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("dut0 reached_10th_pulse", 32'(rises[0] == 10 && sclk[0] === 1'b1), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("dut0 abort_cs_n", 32'(cs_n[0]), 1);
        check("dut0 abort_sclk", 32'(sclk[0]), 0);
        check("dut0 abort_ready", 32'(ready[0]), 1);
        check("dut0 abort_done", 32'(done[0]), 0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        send(0, 1'b0, 16'h00AA, 8'h00, 1'b1);
        wait_idle(0);
        check("dut0 read_after_abort", 32'(rdata[0]), 32'h86);

        send(1, 1'b0, 16'h0010, 8'h00, 1'b1);
        wait_idle(1);
        check("dut1 read_0010", 32'(rdata[1]), 32'h3C);
        send(1, 1'b1, 16'h00FF, 8'h11, 1'b1);
        wait_idle(1);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
